// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_operand_stage_if                                      |
// | Description : Bundle of decode-side, forwarding-source and ALU-side       |
// |               signals around the ID/EX operand stage.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);

  // Decode slot
  logic              id_valid;
  logic [3:0]        id_alu_operation;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic [ADDR_W-1:0] id_rd_addr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic              id_use_imm;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic              id_mem_read;

  // Pipeline control
  logic              flush;
  logic              ex_hold;

  // Forwarding sources
  logic              mem_reg_write;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_rd_addr;
  logic [DATA_W-1:0] wb_result;

  // Stage outputs
  logic              id_stall;
  logic [3:0]        alu_operation;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [CNT_W-1:0]  stall_count;

  // Upstream pipeline / environment side
  modport master (
    output id_valid, id_alu_operation, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, id_use_imm, id_uses_rt,
           id_reg_write, id_mem_read, flush, ex_hold,
           mem_reg_write, mem_rd_addr, mem_result,
           wb_reg_write, wb_rd_addr, wb_result,
    input  id_stall, alu_operation, operand_1, operand_2, ex_store_data,
           ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read, stall_count
  );

  // Operand stage side
  modport slave (
    input  id_valid, id_alu_operation, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, id_use_imm, id_uses_rt,
           id_reg_write, id_mem_read, flush, ex_hold,
           mem_reg_write, mem_rd_addr, mem_result,
           wb_reg_write, wb_rd_addr, wb_result,
    output id_stall, alu_operation, operand_1, operand_2, ex_store_data,
           ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read, stall_count
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : id_ex_operand_stage                                         |
// | Description : ID/EX pipeline register feeding the integer ALU. Forwards  |
// |               from MEM/WB, detects load-use hazards, inserts bubbles and  |
// |               keeps a saturating stall counter.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active low
  id_ex_operand_stage_if.slave  bus
);

  // Unused ALU code: the ALU produces 0 for it, so a bubble is harmless.
  localparam logic [3:0]       c_op_bubble = 4'b1111;
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  // Pipeline registers
  logic              ex_valid_q,     ex_valid_d;
  logic [3:0]        ex_op_q,        ex_op_d;
  logic [ADDR_W-1:0] ex_rs_addr_q,   ex_rs_addr_d;
  logic [ADDR_W-1:0] ex_rt_addr_q,   ex_rt_addr_d;
  logic [ADDR_W-1:0] ex_rd_addr_q,   ex_rd_addr_d;
  logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic              ex_use_imm_q,   ex_use_imm_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic [CNT_W-1:0]  stall_cnt_q,    stall_cnt_d;

  // Combinational
  logic              w_ex_is_load;
  logic              w_rs_hit;
  logic              w_rt_hit;
  logic              w_load_use;
  logic              w_stall;
  logic              w_bubble;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load-use detection against the load currently sitting in EX.
  always_comb begin
    w_ex_is_load = ex_valid_q & ex_mem_read_q & (ex_rd_addr_q != '0);
    w_rs_hit     = (ex_rd_addr_q == bus.id_rs_addr);
    w_rt_hit     = bus.id_uses_rt & (ex_rd_addr_q == bus.id_rt_addr);
    w_load_use   = w_ex_is_load & (w_rs_hit | w_rt_hit) & bus.id_valid;
    w_stall      = w_load_use | bus.ex_hold;
    // Flush and load-use both turn the incoming slot into a bubble.
    w_bubble     = bus.flush | w_load_use | ~bus.id_valid;
  end

  // Next-state of the EX slot: hold, bubble, or capture the decode fields.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_op_d        = ex_op_q;
    ex_rs_addr_d   = ex_rs_addr_q;
    ex_rt_addr_d   = ex_rt_addr_q;
    ex_rd_addr_d   = ex_rd_addr_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    ex_use_imm_d   = ex_use_imm_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    if (bus.ex_hold) begin
      // Downstream freeze wins over everything, including flush.
    end else if (w_bubble) begin
      ex_valid_d     = 1'b0;
      ex_op_d        = c_op_bubble;
      ex_rs_addr_d   = '0;
      ex_rt_addr_d   = '0;
      ex_rd_addr_d   = '0;
      ex_rs_data_d   = '0;
      ex_rt_data_d   = '0;
      ex_imm_d       = '0;
      ex_use_imm_d   = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
    end else begin
      ex_valid_d     = 1'b1;
      ex_op_d        = bus.id_alu_operation;
      ex_rs_addr_d   = bus.id_rs_addr;
      ex_rt_addr_d   = bus.id_rt_addr;
      ex_rd_addr_d   = bus.id_rd_addr;
      ex_rs_data_d   = bus.id_rs_data;
      ex_rt_data_d   = bus.id_rt_data;
      ex_imm_d       = bus.id_imm;
      ex_use_imm_d   = bus.id_use_imm;
      ex_reg_write_d = bus.id_reg_write;
      ex_mem_read_d  = bus.id_mem_read;
    end
  end

  // Stall counter next-state: count stalled edges, stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != c_cnt_max)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset clears the slot to a bubble and zeroes the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_op_q        <= c_op_bubble;
      ex_rs_addr_q   <= '0;
      ex_rt_addr_q   <= '0;
      ex_rd_addr_q   <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_use_imm_q   <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op_q        <= ex_op_d;
      ex_rs_addr_q   <= ex_rs_addr_d;
      ex_rt_addr_q   <= ex_rt_addr_d;
      ex_rd_addr_q   <= ex_rd_addr_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_use_imm_q   <= ex_use_imm_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Operand forwarding: r0 is never forwarded, MEM is younger so it beats WB.
  always_comb begin
    w_fwd_rs = ex_rs_data_q;
    if (ex_rs_addr_q != '0) begin
      if (bus.mem_reg_write && (bus.mem_rd_addr == ex_rs_addr_q)) begin
        w_fwd_rs = bus.mem_result;
      end else if (bus.wb_reg_write && (bus.wb_rd_addr == ex_rs_addr_q)) begin
        w_fwd_rs = bus.wb_result;
      end
    end
    w_fwd_rt = ex_rt_data_q;
    if (ex_rt_addr_q != '0) begin
      if (bus.mem_reg_write && (bus.mem_rd_addr == ex_rt_addr_q)) begin
        w_fwd_rt = bus.mem_result;
      end else if (bus.wb_reg_write && (bus.wb_rd_addr == ex_rt_addr_q)) begin
        w_fwd_rt = bus.wb_result;
      end
    end
  end

  // Output drive
  always_comb begin
    bus.id_stall      = w_stall;
    bus.alu_operation = ex_op_q;
    bus.operand_1     = w_fwd_rs;
    bus.operand_2     = ex_use_imm_q ? ex_imm_q : w_fwd_rt;
    bus.ex_store_data = w_fwd_rt;
    bus.ex_valid      = ex_valid_q;
    bus.ex_rd_addr    = ex_rd_addr_q;
    bus.ex_reg_write  = ex_reg_write_q & ex_valid_q;
    bus.ex_mem_read   = ex_mem_read_q & ex_valid_q;
    bus.stall_count   = stall_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_id_ex_operand_stage                                      |
// | Description : Scoreboard bench for id_ex_operand_stage; a 16-bit counter  |
// |               instance and a 4-bit counter instance share all stimulus.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_id_ex_operand_stage;

  logic clk;
  logic reset_n;

  id_ex_operand_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus16();
  id_ex_operand_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4();

  id_ex_operand_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) u_dut16 (
    .clk(clk), .reset(reset_n), .bus(bus16));
  id_ex_operand_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst_n; bit valid; bit [3:0] op;
    bit [4:0] rs, rt, rd; bit [31:0] rsd, rtd, imm;
    bit use_imm, uses_rt, rw, mr, flush, hold;
    bit mrw; bit [4:0] mrd; bit [31:0] mres;
    bit wrw; bit [4:0] wrd; bit [31:0] wres;
  } stim_t;

  // The instruction occupying EX, as the specification describes it.
  typedef struct {
    bit valid; bit [3:0] op; bit [4:0] rs, rt, rd;
    bit [31:0] rsd, rtd, imm; bit use_imm, rw, mr;
  } slot_t;

  typedef struct {
    bit [3:0] op; bit [31:0] op1, op2, st; bit valid; bit [4:0] rd;
    bit rw, mr, stall; bit [15:0] cnt16; bit [3:0] cnt4;
  } exp_t;

  exp_t  sb_q[$];
  slot_t slot;
  int    stalls;
  int    checks   = 0;
  int    failures = 0;

  function automatic slot_t bubble();
    slot_t b;
    b = '{valid: 0, op: 4'hF, rs: 0, rt: 0, rd: 0, rsd: 0, rtd: 0, imm: 0,
          use_imm: 0, rw: 0, mr: 0};
    return b;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1, valid: 0, op: 0, rs: 0, rt: 0, rd: 0, rsd: 0, rtd: 0, imm: 0,
          use_imm: 0, uses_rt: 0, rw: 0, mr: 0, flush: 0, hold: 0,
          mrw: 0, mrd: 0, mres: 0, wrw: 0, wrd: 0, wres: 0};
    return s;
  endfunction

  // Value seen by the ALU for register r: youngest producer wins, r0 is constant.
  function automatic bit [31:0] operand_value(bit [4:0] r, bit [31:0] regval, stim_t s);
    if (r == 0) return regval;
    if (s.mrw && s.mrd == r) return s.mres;
    if (s.wrw && s.wrd == r) return s.wres;
    return regval;
  endfunction

  task automatic drive(input stim_t s);
    reset_n = s.rst_n;
    bus16.id_valid = s.valid;      bus4.id_valid = s.valid;
    bus16.id_alu_operation = s.op; bus4.id_alu_operation = s.op;
    bus16.id_rs_addr = s.rs;       bus4.id_rs_addr = s.rs;
    bus16.id_rt_addr = s.rt;       bus4.id_rt_addr = s.rt;
    bus16.id_rd_addr = s.rd;       bus4.id_rd_addr = s.rd;
    bus16.id_rs_data = s.rsd;      bus4.id_rs_data = s.rsd;
    bus16.id_rt_data = s.rtd;      bus4.id_rt_data = s.rtd;
    bus16.id_imm = s.imm;          bus4.id_imm = s.imm;
    bus16.id_use_imm = s.use_imm;  bus4.id_use_imm = s.use_imm;
    bus16.id_uses_rt = s.uses_rt;  bus4.id_uses_rt = s.uses_rt;
    bus16.id_reg_write = s.rw;     bus4.id_reg_write = s.rw;
    bus16.id_mem_read = s.mr;      bus4.id_mem_read = s.mr;
    bus16.flush = s.flush;         bus4.flush = s.flush;
    bus16.ex_hold = s.hold;        bus4.ex_hold = s.hold;
    bus16.mem_reg_write = s.mrw;   bus4.mem_reg_write = s.mrw;
    bus16.mem_rd_addr = s.mrd;     bus4.mem_rd_addr = s.mrd;
    bus16.mem_result = s.mres;     bus4.mem_result = s.mres;
    bus16.wb_reg_write = s.wrw;    bus4.wb_reg_write = s.wrw;
    bus16.wb_rd_addr = s.wrd;      bus4.wb_rd_addr = s.wrd;
    bus16.wb_result = s.wres;      bus4.wb_result = s.wres;
  endtask

  // One clock cycle: apply inputs, push the expected outputs, advance the model.
  task automatic step(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #2;
    drive(s);
    if (!s.rst_n) begin
      slot   = bubble();
      stalls = 0;
    end
    #2;
    lu = slot.valid && slot.mr && slot.rd != 0 && s.valid &&
         (slot.rd == s.rs || (s.uses_rt && slot.rd == s.rt));
    e.op    = slot.op;
    e.op1   = operand_value(slot.rs, slot.rsd, s);
    e.st    = operand_value(slot.rt, slot.rtd, s);
    e.op2   = slot.use_imm ? slot.imm : e.st;
    e.valid = slot.valid;
    e.rd    = slot.rd;
    e.rw    = slot.rw && slot.valid;
    e.mr    = slot.mr && slot.valid;
    e.stall = lu || s.hold;
    e.cnt16 = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
    e.cnt4  = (stalls > 15) ? 4'hF : 4'(stalls);
    sb_q.push_back(e);
    if (s.rst_n) begin
      if (e.stall) stalls++;
      if (s.hold) begin
        // frozen
      end else if (s.flush || lu || !s.valid) begin
        slot = bubble();
      end else begin
        slot = '{valid: 1, op: s.op, rs: s.rs, rt: s.rt, rd: s.rd, rsd: s.rsd,
                 rtd: s.rtd, imm: s.imm, use_imm: s.use_imm, rw: s.rw, mr: s.mr};
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every negedge with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("alu_operation", bus16.alu_operation, e.op);
        chk("operand_1",     bus16.operand_1,     e.op1);
        chk("operand_2",     bus16.operand_2,     e.op2);
        chk("ex_store_data", bus16.ex_store_data, e.st);
        chk("ex_valid",      bus16.ex_valid,      e.valid);
        chk("ex_rd_addr",    bus16.ex_rd_addr,    e.rd);
        chk("ex_reg_write",  bus16.ex_reg_write,  e.rw);
        chk("ex_mem_read",   bus16.ex_mem_read,   e.mr);
        chk("id_stall",      bus16.id_stall,      e.stall);
        chk("stall_count16", bus16.stall_count,   e.cnt16);
        chk("stall_count4",  bus4.stall_count,    e.cnt4);
        chk("operand_1_w4",  bus4.operand_1,      e.op1);
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    slot   = bubble();
    stalls = 0;
    drive(idle());
    reset_n = 1'b0;

    // Reset state
    s = idle(); s.rst_n = 0;
    repeat (2) step(s);

    // Capture: add rs=3(5), rt=4(7), rd=8
    s = idle(); s.valid = 1; s.op = 4'b0010; s.rs = 3; s.rt = 4; s.rd = 8;
    s.rsd = 5; s.rtd = 7; s.uses_rt = 1; s.rw = 1;
    step(s);
    step(idle());

    // Forward priority: rs=8, MEM and WB both target r8
    s = idle(); s.valid = 1; s.op = 4'b0011; s.rs = 8; s.rt = 0; s.rd = 2;
    s.rsd = 32'h99; s.rw = 1;
    step(s);
    s = idle(); s.mrw = 1; s.mrd = 8; s.mres = 32'h11; s.wrw = 1; s.wrd = 8; s.wres = 32'h22;
    step(s);
    // rs=0 with both sources targeting r0
    s = idle(); s.valid = 1; s.op = 4'b0110; s.rs = 0; s.rt = 0; s.rd = 3;
    s.rsd = 32'hABCD; s.rtd = 32'h1234; s.uses_rt = 1; s.rw = 1;
    step(s);
    s = idle(); s.mrw = 1; s.mrd = 0; s.mres = 32'h11; s.wrw = 1; s.wrd = 0; s.wres = 32'h22;
    step(s);

    // Load-use: fresh reset, lw r9 then add using r9
    s = idle(); s.rst_n = 0;
    step(s);
    s = idle(); s.valid = 1; s.op = 4'b0010; s.rs = 1; s.rd = 9; s.imm = 4;
    s.use_imm = 1; s.rw = 1; s.mr = 1;
    step(s);
    s = idle(); s.valid = 1; s.op = 4'b0010; s.rs = 9; s.rt = 5; s.rd = 10;
    s.rsd = 32'h55; s.rtd = 32'h66; s.uses_rt = 1; s.rw = 1;
    step(s);        // stalled, bubble enters EX
    step(s);        // reissued
    s = idle(); s.mrw = 1; s.mrd = 9; s.mres = 32'hCAFE;
    step(s);

    // Flush together with load-use
    s = idle(); s.valid = 1; s.op = 4'b0010; s.rs = 2; s.rd = 6; s.rw = 1; s.mr = 1;
    s.use_imm = 1; s.imm = 8;
    step(s);
    s = idle(); s.valid = 1; s.op = 4'b0111; s.rs = 4; s.rt = 6; s.rd = 7;
    s.uses_rt = 1; s.rw = 1; s.flush = 1;
    step(s);
    step(idle());

    // Hold for 3 cycles with a valid instruction in EX
    s = idle(); s.valid = 1; s.op = 4'b1100; s.rs = 5; s.rt = 6; s.rd = 11;
    s.rsd = 32'h0F0F; s.rtd = 32'hF0F0; s.uses_rt = 1; s.rw = 1;
    step(s);
    s.hold = 1; s.op = 4'b0000; s.rd = 12; s.flush = 1;
    repeat (3) step(s);
    step(idle());

    // Saturation: 20 cycles of hold
    s = idle(); s.hold = 1;
    repeat (20) step(s);
    step(idle());

    // Randomized traffic with small register space to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.rst_n   = ($urandom_range(0, 199) != 0);
      s.valid   = ($urandom_range(0, 9) != 0);
      s.op      = 4'($urandom);
      s.rs      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      s.rt      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 3));
      s.rsd     = $urandom;
      s.rtd     = $urandom;
      s.imm     = $urandom;
      s.use_imm = 1'($urandom);
      s.uses_rt = 1'($urandom);
      s.rw      = 1'($urandom);
      s.mr      = ($urandom_range(0, 2) == 0);
      s.flush   = ($urandom_range(0, 9) == 0);
      s.hold    = ($urandom_range(0, 9) == 0);
      s.mrw     = 1'($urandom);
      s.mrd     = 5'($urandom_range(0, 3));
      s.mres    = $urandom;
      s.wrw     = 1'($urandom);
      s.wrd     = 5'($urandom_range(0, 3));
      s.wres    = $urandom;
      step(s);
    end

    // Drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (sb_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
